// File: rtl/iter_shifter_if.sv
// Request/response bundle for the iterative shifter.
// Master issues requests and consumes results; slave is the shifter itself.
interface iter_shifter_if #(
  parameter int unsigned WIDTH = 16
);
  localparam int unsigned AMT_W = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [AMT_W-1:0] amt;
  logic [WIDTH-1:0] data_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] data_out;
  logic             busy;

  modport master (
    output in_valid, op, amt, data_in, out_ready,
    input  in_ready, out_valid, data_out, busy
  );

  modport slave (
    input  in_valid, op, amt, data_in, out_ready,
    output in_ready, out_valid, data_out, busy
  );
endinterface

// File: rtl/iter_shifter.sv
// Multi-cycle barrel-shift replacement: shifts data_out by up to STEP bits per cycle
// until the latched amount is consumed, then holds the result until it is taken.
module iter_shifter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned STEP  = 2
) (
  input  logic          clk,
  input  logic          rst,
  iter_shifter_if.slave bus
);
  localparam int unsigned AMT_W = $clog2(WIDTH);
  localparam logic [AMT_W:0] WidthW = (AMT_W + 1)'(WIDTH);
  localparam logic [AMT_W:0] StepW  = (AMT_W + 1)'(STEP);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [AMT_W-1:0] step_amt;
  logic [AMT_W:0]   comp_amt;
  logic [WIDTH-1:0] shifted;
  logic             accept;

  assign accept = bus.in_valid && (state_q == StIdle);

  // min(STEP, remaining); remaining < WIDTH, so the STEP branch never truncates when it is taken
  assign step_amt = ({1'b0, rem_q} < StepW) ? rem_q : AMT_W'(STEP);
  assign comp_amt = WidthW - {1'b0, step_amt};

  always_comb begin
    shifted = data_q;
    case (op_q)
      3'd0:    shifted = (data_q << step_amt) | (data_q >> comp_amt);
      3'd1:    shifted = data_q << step_amt;
      3'd2:    shifted = $unsigned($signed(data_q) >>> step_amt);
      3'd3:    shifted = data_q >> step_amt;
      default: shifted = (data_q >> step_amt) | (data_q << comp_amt);
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      op_q    <= '0;
      rem_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.in_valid) state_d = (bus.amt == '0) ? StDone : StShift;
      StShift: if (rem_q == step_amt) state_d = StDone;
      StDone:  if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    op_d   = op_q;
    rem_d  = rem_q;
    data_d = data_q;
    if (accept) begin
      op_d   = bus.op;
      rem_d  = bus.amt;
      data_d = bus.data_in;
    end else if (state_q == StShift) begin
      rem_d  = rem_q - step_amt;
      data_d = shifted;
    end
  end

  always_comb begin
    bus.in_ready  = (state_q == StIdle);
    bus.out_valid = (state_q == StDone);
    bus.busy      = (state_q != StIdle);
    bus.data_out  = data_q;
  end
endmodule

// File: tb/tb_iter_shifter.sv
// Directed bench for iter_shifter: three instances (STEP 1, 2, 4) share one stimulus and
// are checked every cycle against a whole-shift reference model plus literal expectations.
module tb_iter_shifter;
  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [2:0]  op;
  logic [3:0]  amt;
  logic [15:0] data_in;
  logic        out_ready;

  logic [2:0]        ir, ov, bz;
  logic [2:0][15:0]  dout;

  int tests = 0;
  int fails = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    iter_shifter_if #(.WIDTH(16)) bus ();
    assign bus.in_valid  = in_valid;
    assign bus.op        = op;
    assign bus.amt       = amt;
    assign bus.data_in   = data_in;
    assign bus.out_ready = out_ready;
    assign ir[g]   = bus.in_ready;
    assign ov[g]   = bus.out_valid;
    assign bz[g]   = bus.busy;
    assign dout[g] = bus.data_out;

    iter_shifter #(.WIDTH(16), .STEP(1 << g)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Whole-operand reference: one shift of the original value by the full amount
  function automatic logic [15:0] ref_shift(input logic [2:0] o, input int a,
                                            input logic [15:0] d);
    logic [31:0] dd;
    dd = {d, d};
    case (o)
      3'd0: begin dd = dd << a; return dd[31:16]; end
      3'd1: return d << a;
      3'd2: return $unsigned($signed(d) >>> a);
      3'd3: return d >> a;
      default: begin dd = dd >> a; return dd[15:0]; end
    endcase
  endfunction

  function automatic int ref_lat(input int a, input int s);
    return (a + s - 1) / s;
  endfunction

  // Per-instance model state, advanced once per cycle
  logic        m_busy [3];
  int          m_wait [3];
  logic [15:0] m_res  [3];
  logic [15:0] m_last [3];

  initial begin
    for (int g = 0; g < 3; g++) begin
      m_busy[g] = 1'b0;
      m_wait[g] = 0;
      m_res[g]  = '0;
      m_last[g] = '0;
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (!rst) begin
        m_busy[g] = 1'b0;
        m_last[g] = '0;
        chk($sformatf("rst_flags[%0d]", g), {ir[g], ov[g], bz[g]}, 3'b100);
        chk($sformatf("rst_data[%0d]", g), dout[g], 16'h0);
      end else begin
        if (!m_busy[g]) begin
          chk($sformatf("idle_flags[%0d]", g), {ir[g], ov[g], bz[g]}, 3'b100);
          chk($sformatf("idle_data[%0d]", g), dout[g], m_last[g]);
        end else if (m_wait[g] > 0) begin
          chk($sformatf("shift_flags[%0d]", g), {ir[g], ov[g], bz[g]}, 3'b001);
        end else begin
          chk($sformatf("done_flags[%0d]", g), {ir[g], ov[g], bz[g]}, 3'b011);
          chk($sformatf("done_data[%0d]", g), dout[g], m_res[g]);
        end
        if (!m_busy[g]) begin
          if (in_valid) begin
            m_busy[g] = 1'b1;
            m_res[g]  = ref_shift(op, int'(amt), data_in);
            m_wait[g] = ref_lat(int'(amt), 1 << g);
          end
        end else if (m_wait[g] > 0) begin
          m_wait[g]--;
        end else if (out_ready) begin
          m_busy[g] = 1'b0;
          m_last[g] = m_res[g];
        end
      end
    end
  end

  // Issue one request, check result and latency per instance, optionally hold DONE, release
  task automatic run(input string name, input logic [2:0] o, input logic [3:0] a,
                     input logic [15:0] d, input logic [15:0] exp,
                     input int l1, input int l2, input int l4, input int hold);
    logic [2:0] seen;
    int         lat [3];
    int         exp_lat [3];
    exp_lat[0] = l1;
    exp_lat[1] = l2;
    exp_lat[2] = l4;
    seen = '0;
    for (int g = 0; g < 3; g++) lat[g] = -1;
    in_valid = 1'b1;
    op       = o;
    amt      = a;
    data_in  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op       = ~o;
    amt      = ~a;
    data_in  = ~d;
    for (int cyc = 0; cyc <= 40; cyc++) begin
      for (int g = 0; g < 3; g++) begin
        if (!seen[g] && ov[g]) begin
          seen[g] = 1'b1;
          lat[g]  = cyc;
        end
      end
      if (&seen) break;
      @(posedge clk);
      #1;
    end
    chk({name, "_completed"}, seen, 3'b111);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("%s_data[step%0d]", name, 1 << g), dout[g], exp);
      chk($sformatf("%s_lat[step%0d]", name, 1 << g), lat[g], exp_lat[g]);
    end
    if (hold > 0) begin
      in_valid = 1'b1;
      data_in  = 16'h5A5A;
      amt      = 4'd0;
      for (int c = 0; c < hold; c++) begin
        @(posedge clk);
        #1;
        chk($sformatf("%s_hold_flags", name), {ir, ov}, {3'b000, 3'b111});
        chk($sformatf("%s_hold_data", name), dout, {exp, exp, exp});
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({name, "_release"}, {ir, ov}, {3'b111, 3'b000});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    op        = '0;
    amt       = '0;
    data_in   = '0;
    out_ready = 1'b0;

    chk("model_rol", ref_shift(3'd0, 4, 16'h1234), 16'h2341);
    chk("model_ror", ref_shift(3'd5, 4, 16'h1234), 16'h4123);
    chk("model_sra", ref_shift(3'd2, 3, 16'h8001), 16'hF000);
    chk("model_lat", ref_lat(15, 2), 8);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    run("sll",    3'd1, 4'd4,  16'h00FF, 16'h0FF0, 4,  2, 1, 5);
    run("sra",    3'd2, 4'd3,  16'h8001, 16'hF000, 3,  2, 1, 0);
    run("srl15",  3'd3, 4'd15, 16'hF000, 16'h0001, 15, 8, 4, 0);
    run("rol",    3'd0, 4'd4,  16'h1234, 16'h2341, 4,  2, 1, 0);
    run("ror",    3'd5, 4'd4,  16'h1234, 16'h4123, 4,  2, 1, 0);
    run("amt0",   3'd2, 4'd0,  16'hBEEF, 16'hBEEF, 0,  0, 0, 0);
    run("ror1",   3'd7, 4'd1,  16'h0001, 16'h8000, 1,  1, 1, 0);
    run("sra_pos", 3'd2, 4'd14, 16'h4000, 16'h0001, 14, 7, 4, 0);
    run("rol15",  3'd0, 4'd15, 16'h8421, 16'hC210, 15, 8, 4, 0);

    // Reset in the middle of a long shift
    in_valid = 1'b1;
    op       = 3'd3;
    amt      = 4'd15;
    data_in  = 16'hF000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_flags", {ir, ov, bz}, {3'b111, 3'b000, 3'b000});
    chk("midrst_data", dout, 48'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("postrst_no_valid", ov, 3'b000);
    end
    run("after_rst", 3'd1, 4'd1, 16'h8003, 16'h0006, 1, 1, 1, 0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
